register_reader: RTL and testbench

REGISTER_READER -- requirements
Module: register_reader

---
 rtl/register_reader_pkg.sv | 33 +++
 rtl/register_reader_bypass_merge.sv | 40 ++++
 rtl/register_reader.sv | 171 +++++++++++++++++
 tb/tb_register_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_reader_pkg.sv
// -----------------------------------------------------------------------------
// register_reader_pkg
// Shared definitions for the register reader:
//   - register index constants (AX..DI in register-file order)
//   - write_part encodings used by the register-file write port
//   - reader state enum and the index of the final burst beat
// -----------------------------------------------------------------------------
package register_reader_pkg;

   localparam logic [2:0] REG_AX = 3'd0;
   localparam logic [2:0] REG_CX = 3'd1;
   localparam logic [2:0] REG_DX = 3'd2;
   localparam logic [2:0] REG_BX = 3'd3;
   localparam logic [2:0] REG_SP = 3'd4;
   localparam logic [2:0] REG_BP = 3'd5;
   localparam logic [2:0] REG_SI = 3'd6;
   localparam logic [2:0] REG_DI = 3'd7;

   localparam logic [1:0] PART_NONE = 2'b00;
   localparam logic [1:0] PART_LO   = 2'b01;
   localparam logic [1:0] PART_HI   = 2'b10;
   localparam logic [1:0] PART_W    = 2'b11;

   // A burst always walks the whole file; this is the index of its final beat.
   localparam logic [2:0] LAST_BEAT = REG_DI;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      BURST  = 2'd2
   } reader_state_t;

endpackage

// File: rtl/register_reader_bypass_merge.sv
// -----------------------------------------------------------------------------
// reg_bypass_merge
// Combinational bypass: returns the value register k will hold after this
// cycle's register-file write, so a read issued alongside a write sees it.
// Ports:
//   value      - current contents of register k
//   we         - register-file write enable this cycle
//   write_part - which bytes the write touches (PART_LO/PART_HI/PART_W)
//   write_id   - register index being written
//   write_data - write data (byte lanes chosen by write_part)
//   k          - register index this instance is merging for
//   merged     - value of register k with the concurrent write applied
// -----------------------------------------------------------------------------
module reg_bypass_merge
   import register_reader_pkg::*;
(
   input  logic [15:0] value,
   input  logic        we,
   input  logic [1:0]  write_part,
   input  logic [2:0]  write_id,
   input  logic [15:0] write_data,
   input  logic [2:0]  k,
   output logic [15:0] merged
);

   // NOTE: every variable written in an always_comb gets a default first, so
   // no path through the block can leave it unassigned and infer a latch.
   always_comb begin
      merged = value;
      if (we && (write_id == k)) begin
         case (write_part)
            PART_LO: merged[7:0]  = write_data[7:0];
            PART_HI: merged[15:8] = write_data[15:8];
            PART_W:  merged       = write_data;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/register_reader.sv
// -----------------------------------------------------------------------------
// register_reader
// Reads the 8 x 16-bit general register file on request, with a bypass from
// the concurrent register-file write. A request is either a single word read,
// a single byte read (AL..BL / AH..BH encoding, zero-extended), or a burst of
// all eight words in index order. Responses are registered (1-cycle latency)
// and held stable under backpressure; burst beats stream without bubbles.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   registers                      - current register-file contents, [k] = reg k
//   we, write_part, write_id,
//   write_data                     - register-file write port this cycle (bypass)
//   req_valid/req_ready            - request handshake
//   req_id, req_byte, req_burst    - request register, byte encoding, burst flag
//   rsp_valid/rsp_ready            - response handshake
//   rsp_data, rsp_last             - response word, final-beat marker
// -----------------------------------------------------------------------------
module register_reader
   import register_reader_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0][15:0] registers,
   input  logic             we,
   input  logic [1:0]       write_part,
   input  logic [2:0]       write_id,
   input  logic [15:0]      write_data,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_id,
   input  logic             req_byte,
   input  logic             req_burst,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_data,
   output logic             rsp_last
);

   reader_state_t state, state_nxt;
   logic [2:0]    beat_cnt, beat_cnt_nxt;
   logic [15:0]   sp_snap, sp_snap_nxt;
   logic          rsp_valid_nxt;
   logic [15:0]   rsp_data_nxt;
   logic          rsp_last_nxt;

   logic [2:0]    sel_idx;
   logic [2:0]    next_beat;
   logic [15:0]   sel_merged;
   logic [15:0]   sp_merged;

   assign next_beat = beat_cnt + 3'd1;

   // Only one register is ever read per edge: the request target while idle,
   // or the beat about to be loaded while bursting. Byte reads of ids 4-7 map
   // onto the high byte of registers 0-3.
   always_comb begin
      sel_idx = req_id;
      if (state == BURST)
         sel_idx = next_beat;
      else if (req_burst)
         sel_idx = REG_AX;
      else if (req_byte)
         sel_idx = {1'b0, req_id[1:0]};
   end

   reg_bypass_merge u_sel_merge (
      .value      (registers[sel_idx]),
      .we         (we),
      .write_part (write_part),
      .write_id   (write_id),
      .write_data (write_data),
      .k          (sel_idx),
      .merged     (sel_merged)
   );

   // SP is snapshotted when a burst is accepted; beat 4 replays that snapshot
   // so a burst sees a consistent stack pointer even if SP moves mid-burst.
   reg_bypass_merge u_sp_merge (
      .value      (registers[REG_SP]),
      .we         (we),
      .write_part (write_part),
      .write_id   (write_id),
      .write_data (write_data),
      .k          (REG_SP),
      .merged     (sp_merged)
   );

   assign req_ready = (state == IDLE);

   always_comb begin
      state_nxt     = state;
      beat_cnt_nxt  = beat_cnt;
      sp_snap_nxt   = sp_snap;
      rsp_valid_nxt = rsp_valid;
      rsp_data_nxt  = rsp_data;
      rsp_last_nxt  = rsp_last;

      case (state)
         IDLE: begin
            if (req_valid) begin
               rsp_valid_nxt = 1'b1;
               if (req_burst) begin
                  state_nxt    = BURST;
                  beat_cnt_nxt = 3'd0;
                  sp_snap_nxt  = sp_merged;
                  rsp_data_nxt = sel_merged;
                  rsp_last_nxt = 1'b0;
               end else begin
                  state_nxt    = SINGLE;
                  rsp_last_nxt = 1'b1;
                  if (req_byte)
                     rsp_data_nxt = req_id[2] ? {8'h00, sel_merged[15:8]}
                                              : {8'h00, sel_merged[7:0]};
                  else
                     rsp_data_nxt = sel_merged;
               end
            end
         end

         SINGLE: begin
            if (rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
               rsp_last_nxt  = 1'b0;
            end
         end

         BURST: begin
            if (rsp_ready) begin
               if (beat_cnt == LAST_BEAT) begin
                  state_nxt     = IDLE;
                  rsp_valid_nxt = 1'b0;
                  rsp_last_nxt  = 1'b0;
               end else begin
                  // Next beat loads on the completing edge: no bubble.
                  beat_cnt_nxt = next_beat;
                  rsp_data_nxt = (next_beat == REG_SP) ? sp_snap : sel_merged;
                  rsp_last_nxt = (next_beat == LAST_BEAT);
               end
            end
         end

         default: begin
            state_nxt     = IDLE;
            rsp_valid_nxt = 1'b0;
            rsp_last_nxt  = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         beat_cnt  <= 3'd0;
         sp_snap   <= 16'h0000;
         rsp_valid <= 1'b0;
         rsp_data  <= 16'h0000;
         rsp_last  <= 1'b0;
      end else begin
         state     <= state_nxt;
         beat_cnt  <= beat_cnt_nxt;
         sp_snap   <= sp_snap_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_data  <= rsp_data_nxt;
         rsp_last  <= rsp_last_nxt;
      end
   end

endmodule

// File: tb/tb_register_reader.sv
// -----------------------------------------------------------------------------
// tb_register_reader
// Self-checking bench for register_reader: directed scenarios followed by
// randomized singles and bursts, checked against a behavioural model that
// computes each expected response from the register contents and the write
// port present on the loading edge.
// -----------------------------------------------------------------------------
module tb_register_reader;

   logic             clk = 1'b0;
   logic             reset;
   logic [7:0][15:0] registers;
   logic             we;
   logic [1:0]       write_part;
   logic [2:0]       write_id;
   logic [15:0]      write_data;
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_id;
   logic             req_byte;
   logic             req_burst;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [15:0]      rsp_data;
   logic             rsp_last;

   int n_cmp = 0;
   int n_err = 0;

   register_reader dut (
      .clk        (clk),
      .reset      (reset),
      .registers  (registers),
      .we         (we),
      .write_part (write_part),
      .write_id   (write_id),
      .write_data (write_data),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_id     (req_id),
      .req_byte   (req_byte),
      .req_burst  (req_burst),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_last   (rsp_last)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Value register k will hold after the write currently on the write port.
   function automatic logic [15:0] view(input int k);
      int v;
      int d;
      v = int'(registers[k]);
      d = int'(write_data);
      if (we && int'(write_id) == k) begin
         if (write_part == 2'b11)      v = d;
         else if (write_part == 2'b01) v = (v / 256) * 256 + d % 256;
         else if (write_part == 2'b10) v = (d / 256) * 256 + v % 256;
      end
      return v[15:0];
   endfunction

   function automatic logic [15:0] single_model(input int id, input logic byte_sel);
      if (!byte_sel)  return view(id);
      if (id < 4)     return 16'(int'(view(id)) % 256);
      return 16'(int'(view(id - 4)) / 256);
   endfunction

   task automatic rand_regs();
      for (int i = 0; i < 8; i++) registers[i] = 16'($urandom);
   endtask

   task automatic rand_write();
      we         = 1'($urandom_range(0, 1));
      write_part = 2'($urandom);
      write_id   = 3'($urandom);
      write_data = 16'($urandom);
   endtask

   task automatic no_write();
      we = 1'b0; write_part = 2'b00; write_id = 3'd0; write_data = 16'h0000;
   endtask

   task automatic do_single(input string name, input logic [2:0] id, input logic byte_sel,
                            input logic w, input logic [1:0] part, input logic [2:0] wid,
                            input logic [15:0] wdata, input int stall);
      logic [15:0] exp;
      req_valid  = 1'b1;  req_burst = 1'b0;
      req_id     = id;    req_byte  = byte_sel;
      we         = w;     write_part = part;
      write_id   = wid;   write_data = wdata;
      rsp_ready  = 1'b0;
      exp = single_model(int'(id), byte_sel);
      tick();
      req_valid = 1'b0;
      no_write();
      check({name, " valid"}, {15'd0, rsp_valid}, 16'd1);
      check({name, " data"},  rsp_data, exp);
      check({name, " last"},  {15'd0, rsp_last}, 16'd1);
      check({name, " busy"},  {15'd0, req_ready}, 16'd0);
      for (int s = 0; s < stall; s++) begin
         rand_regs();
         tick();
         check({name, " held"}, rsp_data, exp);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({name, " done valid"}, {15'd0, rsp_valid}, 16'd0);
      check({name, " done ready"}, {15'd0, req_ready}, 16'd1);
   endtask

   // rnd=1: random writes, register churn and stalls. rnd=0: quiet write port,
   // SP moves to 0x03F0 after accept, and one stall of stall_len at stall_beat.
   task automatic do_burst(input string name, input bit rnd, input int stall_beat,
                           input int stall_len);
      logic [15:0] sp_exp;
      logic [15:0] cur;
      int          stalls;
      req_valid = 1'b1; req_burst = 1'b1;
      req_id    = 3'($urandom); req_byte = 1'($urandom);
      rsp_ready = 1'b0;
      if (rnd) rand_write(); else no_write();
      sp_exp = view(4);
      cur    = view(0);
      tick();
      req_valid = 1'b0; req_burst = 1'b0;
      if (!rnd) registers[4] = 16'h03F0;
      for (int b = 0; b < 8; b++) begin
         check($sformatf("%s b%0d valid", name, b), {15'd0, rsp_valid}, 16'd1);
         check($sformatf("%s b%0d data", name, b), rsp_data, cur);
         check($sformatf("%s b%0d last", name, b), {15'd0, rsp_last}, (b == 7) ? 16'd1 : 16'd0);
         stalls = rnd ? $urandom_range(0, 2) : ((b == stall_beat) ? stall_len : 0);
         for (int s = 0; s < stalls; s++) begin
            rsp_ready = 1'b0;
            if (rnd) begin rand_regs(); rand_write(); end
            tick();
            check($sformatf("%s b%0d stall data", name, b), rsp_data, cur);
            check($sformatf("%s b%0d stall valid", name, b), {15'd0, rsp_valid}, 16'd1);
         end
         rsp_ready = 1'b1;
         if (rnd) begin rand_regs(); rand_write(); end
         if (b < 7) cur = (b + 1 == 4) ? sp_exp : view(b + 1);
         tick();
      end
      rsp_ready = 1'b0;
      no_write();
      check({name, " end valid"}, {15'd0, rsp_valid}, 16'd0);
      check({name, " end ready"}, {15'd0, req_ready}, 16'd1);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_id = 3'd0; req_byte = 1'b0;
      req_burst = 1'b0; rsp_ready = 1'b0;
      no_write();
      for (int i = 0; i < 8; i++) registers[i] = 16'h0000;
      tick(); tick();

      // Reset state, with a request pending to show reset wins.
      req_valid = 1'b1;
      tick();
      check("rst valid", {15'd0, rsp_valid}, 16'd0);
      check("rst data",  rsp_data, 16'h0000);
      check("rst last",  {15'd0, rsp_last}, 16'd0);
      req_valid = 1'b0;
      reset = 1'b0;
      check("rst ready", {15'd0, req_ready}, 16'd1);

      // Directed single reads.
      registers[3] = 16'h1234;
      do_single("word bx", 3'd3, 1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 0);
      registers[1] = 16'hABCD;
      do_single("byte ch", 3'd5, 1'b1, 1'b0, 2'b00, 3'd0, 16'h0, 0);
      do_single("byte cl", 3'd1, 1'b1, 1'b0, 2'b00, 3'd0, 16'h0, 2);
      registers[2] = 16'h1111;
      do_single("bypass hi", 3'd2, 1'b0, 1'b1, 2'b10, 3'd2, 16'hFF00, 0);
      do_single("bypass lo", 3'd2, 1'b0, 1'b1, 2'b01, 3'd2, 16'h00EE, 0);
      do_single("bypass w",  3'd2, 1'b1, 1'b1, 2'b11, 3'd2, 16'h5A77, 0);
      do_single("bypass no", 3'd2, 1'b0, 1'b1, 2'b00, 3'd2, 16'hFFFF, 0);
      do_single("other id",  3'd2, 1'b0, 1'b1, 2'b11, 3'd6, 16'hBEEF, 0);

      // Directed bursts: SP snapshot, then backpressure at beat 2.
      for (int i = 0; i < 8; i++) registers[i] = 16'(16'h0100 * i);
      do_burst("burst sp", 1'b0, -1, 0);
      for (int i = 0; i < 8; i++) registers[i] = 16'(16'h0100 * i);
      do_burst("burst bp", 1'b0, 2, 3);

      // Reset at beat 5 aborts the burst.
      for (int i = 0; i < 8; i++) registers[i] = 16'(16'h0100 * i);
      req_valid = 1'b1; req_burst = 1'b1;
      tick();
      req_valid = 1'b0; req_burst = 1'b0;
      rsp_ready = 1'b1;
      repeat (5) tick();
      check("abort beat5", rsp_data, 16'h0500);
      reset = 1'b1;
      tick();
      reset = 1'b0; rsp_ready = 1'b0;
      check("abort valid", {15'd0, rsp_valid}, 16'd0);
      check("abort ready", {15'd0, req_ready}, 16'd1);
      check("abort data",  rsp_data, 16'h0000);
      check("abort last",  {15'd0, rsp_last}, 16'd0);
      tick();
      check("abort quiet", {15'd0, rsp_valid}, 16'd0);
      registers[0] = 16'hC0DE;
      do_single("after abort", 3'd0, 1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 0);

      // Randomized singles and bursts.
      for (int n = 0; n < 40; n++) begin
         rand_regs();
         do_single($sformatf("rnd single %0d", n), 3'($urandom), 1'($urandom),
                   1'($urandom), 2'($urandom), 3'($urandom), 16'($urandom),
                   $urandom_range(0, 2));
      end
      for (int n = 0; n < 8; n++) begin
         rand_regs();
         do_burst($sformatf("rnd burst %0d", n), 1'b1, 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
